// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch engine between the program counter and instruction memory. A fetch
// address is accepted, a single request/grant/response transaction is run
// against instruction memory, and the returned word is presented to decode
// with its PC over a valid/ready handshake. Jump/branch redirects squash any
// in-flight fetch; stale memory responses are drained and discarded.
//
// Ports:
//   clk, reset       - clock, synchronous active-low reset
//   pc_in, pc_valid  - fetch target from the PC and its qualifier
//   redirect         - taken jump/branch, qualifies pc_valid
//   fetch_stall      - PC must hold (high whenever not idle)
//   mem_req/mem_addr - read request to instruction memory
//   mem_gnt          - memory accepted the request
//   mem_rvalid/rdata - read response
//   instr_out/pc     - instruction and its PC to decode
//   instr_valid      - decode-side valid, instr_ready - decode accepts
//   fetch_fault      - one-cycle pulse on response timeout
//
// Build option: define IFETCH_TIMEOUT_EN to enable the response timeout
// (TIMEOUT_CYCLES). Without it WAIT/DRAIN wait indefinitely and
// fetch_fault is tied low.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned ADDR_W         = 72,
    parameter int unsigned INSTR_W        = 60,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    input  logic               redirect,
    output logic               fetch_stall,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        OUT
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    cur_pc_q;
    logic [ADDR_W-1:0]    next_pc_q;
    logic [INSTR_W-1:0]   instr_buf_q;
    logic [ADDR_W-1:0]    out_pc_q;
    logic                 fault_q;
    logic                 redir;
    logic                 timeout;

    assign redir = redirect & pc_valid;

`ifdef IFETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Fires on the last cycle before the count would reach TIMEOUT_CYCLES,
    // so the registered fault pulse lands exactly TIMEOUT_CYCLES after entry.
    assign timeout = (state_q == WAIT || state_q == DRAIN) && !mem_rvalid &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if ((state_q == WAIT || state_q == DRAIN) && !mem_rvalid) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (pc_valid) state_d = REQ;
            REQ:   if (mem_gnt) state_d = redir ? DRAIN : WAIT;
            WAIT: begin
                if (mem_rvalid)   state_d = redir ? REQ : OUT;
                else if (timeout) state_d = IDLE;
                else if (redir)   state_d = DRAIN;
            end
            DRAIN: if (mem_rvalid || timeout) state_d = REQ;
            OUT: begin
                // A redirect wins over a same-cycle handshake: squash.
                if (redir)            state_d = REQ;
                else if (instr_ready) state_d = pc_valid ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_pc_q    <= '0;
            next_pc_q   <= '0;
            instr_buf_q <= '0;
            out_pc_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE: if (pc_valid) cur_pc_q <= pc_in;
                REQ: begin
                    if (redir) begin
                        if (mem_gnt) next_pc_q <= pc_in;
                        else         cur_pc_q  <= pc_in;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (redir) begin
                            cur_pc_q <= pc_in;
                        end else begin
                            instr_buf_q <= mem_rdata;
                            out_pc_q    <= cur_pc_q;
                        end
                    end else if (timeout) begin
                        fault_q <= 1'b1;
                    end else if (redir) begin
                        next_pc_q <= pc_in;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid || timeout) begin
                        cur_pc_q <= redir ? pc_in : next_pc_q;
                        fault_q  <= timeout;
                    end else if (redir) begin
                        next_pc_q <= pc_in;
                    end
                end
                OUT: if (redir || (instr_ready && pc_valid)) cur_pc_q <= pc_in;
                default: ;
            endcase
        end
    end

    // Outputs decode registers only
    always_comb begin
        fetch_stall = (state_q != IDLE);
        mem_req     = (state_q == REQ);
        instr_valid = (state_q == OUT);
        mem_addr    = cur_pc_q;
        instr_out   = instr_buf_q;
        instr_pc    = out_pc_q;
        fetch_fault = fault_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W  = 72;
    localparam int unsigned INSTR_W = 60;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  pc_in;
    logic               pc_valid;
    logic               redirect;
    logic               fetch_stall;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               fetch_fault;

    instr_fetch_unit #(
        .ADDR_W        (ADDR_W),
        .INSTR_W       (INSTR_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .redirect   (redirect),
        .fetch_stall(fetch_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory contents: a fixed function of the address
    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[59:0] ^ {a[71:60], 48'h0} ^ 60'h0F0F123456789AB;
    endfunction

    typedef struct {
        logic               pv;
        logic [ADDR_W-1:0]  pc;
        logic               rd, gnt, rv;
        logic [INSTR_W-1:0] rdata;
        logic               rdy;
        logic               e_req;
        logic [ADDR_W-1:0]  e_addr;
        logic               e_stall, e_iv;
        logic [INSTR_W-1:0] e_iout;
        logic [ADDR_W-1:0]  e_ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int unsigned pv, pc, rd, gnt, rv, rdata, rdy,
                       input int unsigned e_req, e_addr, e_stall, e_iv, e_iout, e_ipc);
        vec_t v;
        v.pv = pv[0]; v.pc = ADDR_W'(pc); v.rd = rd[0]; v.gnt = gnt[0]; v.rv = rv[0];
        v.rdata = INSTR_W'(rdata); v.rdy = rdy[0];
        v.e_req = e_req[0]; v.e_addr = ADDR_W'(e_addr); v.e_stall = e_stall[0];
        v.e_iv = e_iv[0]; v.e_iout = INSTR_W'(e_iout); v.e_ipc = ADDR_W'(e_ipc);
        vecs.push_back(v);
    endtask

    // Reference model state for the random phase
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] out_addr;
    bit                outstanding;
    bit                pending;
    bit                accept_idle_prev;
    int unsigned       resp_wait;
    int unsigned       stall_run;

    task automatic cycle(input bit allow_pc);
        logic               s_stall, s_req, s_iv;
        logic [ADDR_W-1:0]  s_addr, s_ipc, pc;
        logic [INSTR_W-1:0] s_iout, rdata;
        bit                 busy, pv, rd, rdy, gnt, rv, delivered, accept;
        int unsigned        r;
        @(negedge clk);
        s_stall = fetch_stall; s_req = mem_req; s_iv = instr_valid;
        s_addr = mem_addr; s_ipc = instr_pc; s_iout = instr_out;

        chk("rnd_fault", fetch_fault, 0);
        if (!s_stall) chk("rnd_idle_quiet", {s_iv, s_req}, 0);
        if (s_req) begin
            chk("rnd_req_stall", s_stall, 1);
            chk("rnd_req_addr", s_addr, exp_pc);
            chk("rnd_one_outstanding", outstanding, 0);
        end
        if (s_iv) begin
            chk("rnd_instr_pc", s_ipc, exp_pc);
            chk("rnd_instr_out", s_iout, mem_word(exp_pc));
        end
        if (accept_idle_prev) chk("rnd_req_latency", s_req, 1);
        stall_run = s_stall ? stall_run + 1 : 0;
        if (stall_run > 200) begin
            chk("rnd_liveness", stall_run, 0);
            stall_run = 0;
        end

        // Memory: one response per grant, 0..2 extra cycles of latency
        busy  = outstanding;
        rv    = 1'b0;
        rdata = INSTR_W'({$urandom, $urandom});
        if (busy) begin
            if (resp_wait == 0) begin
                rv = 1'b1;
                rdata = mem_word(out_addr);
                outstanding = 1'b0;
            end else begin
                resp_wait--;
            end
        end else if (!s_stall && $urandom_range(3) == 0) begin
            rv = 1'b1;
        end
        gnt = s_req && ($urandom_range(1) == 1);
        if (gnt) begin
            outstanding = 1'b1;
            out_addr    = s_addr;
            resp_wait   = $urandom_range(2);
        end

        // Program counter / decode side
        r   = $urandom_range(7);
        pc  = {$urandom, $urandom, 8'($urandom)};
        rdy = allow_pc ? ($urandom_range(2) != 0) : 1'b1;
        if (!allow_pc) begin
            pv = 0; rd = 0;
        end else if (!s_stall) begin
            pv = (r < 5); rd = (r == 0);
        end else if (s_iv && rdy) begin
            pv = (r < 4); rd = (r == 0) || (r == 7);
        end else begin
            pv = (r == 0); rd = (r <= 1);
        end

        pc_in = pc; pc_valid = pv; redirect = rd; instr_ready = rdy;
        mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rdata;

        delivered = s_iv && rdy && !(pv && rd);
        if (delivered) pending = 1'b0;
        accept = pv && (!s_stall || rd || (s_iv && rdy));
        if (accept) begin
            exp_pc  = pc;
            pending = 1'b1;
        end
        accept_idle_prev = accept && !s_stall;
    endtask

    task automatic drive_idle();
        pc_valid = 0; redirect = 0; pc_in = '0; mem_gnt = 0;
        mem_rvalid = 0; mem_rdata = '0; instr_ready = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        // pv pc rd gnt rv rdata rdy | req addr stall iv iout ipc
        add(1, 0,   0, 0, 0, 0,      0,  1, 0,   1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      1,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'hABC,  1,  0, 0,   1, 1, 'hABC,  0);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'hFFF,  0,  0, 0,   0, 0, 0,      0);
        // decode backpressure
        add(1, 36,  0, 0, 0, 0,      0,  1, 36,  1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h111,  0,  0, 0,   1, 1, 'h111,  36);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0,    0,  0, 0,   1, 1, 'h111,  36);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);
        // redirect in REQ without grant
        add(1, 100, 0, 0, 0, 0,      0,  1, 100, 1, 0, 0,      0);
        add(1, 144, 1, 0, 0, 0,      0,  1, 144, 1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h144,  0,  0, 0,   1, 1, 'h144,  144);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);
        // redirect in WAIT -> DRAIN, stale data discarded
        add(1, 500, 0, 0, 0, 0,      0,  1, 500, 1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(1, 720, 1, 0, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'hDEAD, 0,  1, 720, 1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h720,  0,  0, 0,   1, 1, 'h720,  720);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);
        // back-to-back fetch on handshake
        add(1, 8,   0, 0, 0, 0,      0,  1, 8,   1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h8,    0,  0, 0,   1, 1, 'h8,    8);
        add(1, 16,  0, 0, 0, 0,      1,  1, 16,  1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h16,   0,  0, 0,   1, 1, 'h16,   16);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);
        // redirect in OUT squashes despite instr_ready
        add(1, 3,   0, 0, 0, 0,      0,  1, 3,   1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h3,    0,  0, 0,   1, 1, 'h3,    3);
        add(1, 40,  1, 0, 0, 0,      1,  1, 40,  1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h40,   0,  0, 0,   1, 1, 'h40,   40);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);
        // redirect with grant -> DRAIN, then DRAIN redirect overwrites target
        add(1, 60,  0, 0, 0, 0,      0,  1, 60,  1, 0, 0,      0);
        add(1, 61,  1, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(1, 62,  1, 0, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'hBAD,  0,  1, 62,  1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h62,   0,  0, 0,   1, 1, 'h62,   62);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);
        // redirect in WAIT together with rvalid
        add(1, 70,  0, 0, 0, 0,      0,  1, 70,  1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(1, 80,  1, 0, 1, 'hBAD,  0,  1, 80,  1, 0, 0,      0);
        add(0, 0,   0, 1, 0, 0,      0,  0, 0,   1, 0, 0,      0);
        add(0, 0,   0, 0, 1, 'h80,   0,  0, 0,   1, 1, 'h80,   80);
        add(0, 0,   0, 0, 0, 0,      1,  0, 0,   0, 0, 0,      0);

        // Reset
        drive_idle();
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_req", mem_req, 0);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_data", {mem_addr, instr_out, instr_pc}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            pc_valid = vecs[i].pv; pc_in = vecs[i].pc; redirect = vecs[i].rd;
            mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rdata;
            instr_ready = vecs[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_req", i), mem_req, vecs[i].e_req);
            if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_stall", i), fetch_stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].e_iv);
            if (vecs[i].e_iv) begin
                chk($sformatf("vec%0d_iout", i), instr_out, vecs[i].e_iout);
                chk($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].e_ipc);
            end
            chk($sformatf("vec%0d_fault", i), fetch_fault, 0);
        end

        // Reset during WAIT; the late response must be ignored
        @(negedge clk); drive_idle(); pc_valid = 1; pc_in = 5;
        @(negedge clk); pc_valid = 0; mem_gnt = 1;
        @(negedge clk); mem_gnt = 0; reset = 1'b0;
        @(posedge clk); #1;
        chk("wrst_ctrl", {mem_req, fetch_stall, instr_valid, fetch_fault}, 0);
        chk("wrst_data", {mem_addr, instr_out, instr_pc}, 0);
        @(negedge clk); reset = 1'b1; mem_rvalid = 1; mem_rdata = 60'h5;
        @(posedge clk); #1;
        chk("wrst_late_valid", instr_valid, 0);
        chk("wrst_late_stall", fetch_stall, 0);
        @(negedge clk); mem_rvalid = 0;
        @(posedge clk); #1;
        chk("wrst_late_valid2", instr_valid, 0);

        // Randomized phase against the handshake-level model
        exp_pc = '0; out_addr = '0; outstanding = 0; pending = 0;
        accept_idle_prev = 0; resp_wait = 0; stall_run = 0;
        for (int n = 0; n < 3000; n++) cycle(1'b1);
        for (int n = 0; n < 100 && (fetch_stall || outstanding); n++) cycle(1'b0);
        chk("rnd_drain_stall", fetch_stall, 0);
        chk("rnd_pending", pending, 0);

`ifdef IFETCH_TIMEOUT_EN
        @(negedge clk); drive_idle(); pc_valid = 1; pc_in = 9;
        @(negedge clk); pc_valid = 0; mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("to_fault_k%0d", k), fetch_fault, (k == 8));
            chk($sformatf("to_stall_k%0d", k), fetch_stall, (k < 8));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
